// File: rtl/add_sink_pkg.sv
// Shared types and width helpers for the add unit's result sink.
package add_sink_pkg;

   localparam int ADD_DATA_W = 32;
   localparam int ADD_DEPTH  = 4;

   typedef logic [ADD_DATA_W-1:0] add_beat_t;

   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/add_sink_fifo.sv
// Power-of-two FIFO with occupancy count; a pop while full lets a push land in the same cycle.
module add_sink_fifo
   import add_sink_pkg::*;
#(
   parameter int DATA_W = ADD_DATA_W,
   parameter int DEPTH  = ADD_DEPTH
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wr_data,
   output logic [DATA_W-1:0]        rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage has no reset; contents are only observable behind a valid count.
   always_ff @(posedge ap_clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/add_sink.sv
// Result sink for one add instance: credit-stalls the producer via ap_ce and buffers beats.
// Optional output beat counter enabled by defining ADD_SINK_BEATCNT_EN.
module add_sink
   import add_sink_pkg::*;
#(
   parameter int DATA_W = ADD_DATA_W,
   parameter int DEPTH  = ADD_DEPTH
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     enable,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_vld,
   output logic                     ap_ce,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
`ifdef ADD_SINK_BEATCNT_EN
   ,
   output logic [31:0]              beat_cnt
`endif
);

   localparam int CNT_W = cnt_w(DEPTH);

   logic             ce_q;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic [CNT_W:0]   credit_used;

   assign pop       = out_valid && out_ready;
   assign out_valid = !fifo_empty;

   // Pops are deliberately not credited so out_ready has no path to ap_ce.
   assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, ce_q};
   assign ap_ce       = enable && (credit_used < (CNT_W+1)'(DEPTH));

   add_sink_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .push     (in_vld),
      .pop      (pop),
      .wr_data  (in_data),
      .rd_data  (out_data),
      .count    (count),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         ce_q <= 1'b0;
         ovf  <= 1'b0;
      end else begin
         ce_q <= ap_ce;
         if (in_vld && fifo_full && !pop) ovf <= 1'b1;
      end
   end

`ifdef ADD_SINK_BEATCNT_EN
   logic [31:0] beat_cnt_q;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)  beat_cnt_q <= '0;
      else if (pop)   beat_cnt_q <= beat_cnt_q + 32'd1;
   end

   assign beat_cnt = beat_cnt_q;
`endif

endmodule
